// File: rtl/cg_bist_sequencer_if.sv
// Control/status bundle of the BIST sequencer: run request, seed/golden in, result and progress out.
interface cg_bist_sequencer_if #(
  parameter int unsigned N_IN  = 25,
  parameter int unsigned SIG_W = 16,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [N_IN-1:0]  seed;
  logic [SIG_W-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt;

  modport master (
    output start, seed, golden,
    input  busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, seed, golden,
    output busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/cg_bist_sequencer.sv
// LFSR-driven BIST sequencer: feeds pseudo-random vectors to a CUT, compacts its responses
// in a MISR and compares the final signature against a golden value.
module cg_bist_sequencer #(
  parameter int unsigned     N_IN      = 25,
  parameter int unsigned     N_OUT     = 11,
  parameter int unsigned     SIG_W     = 16,
  parameter int unsigned     PATTERNS  = 1024,
  parameter int unsigned     CUT_LAT   = 0,
  parameter logic [N_IN-1:0] LFSR_TAPS = 25'h1200000,
  parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cg_bist_sequencer_if.slave   ctl,
  output logic [N_IN-1:0]      cut_x,
  input  logic [N_OUT-1:0]     cut_f
);

  if (PATTERNS < 1) begin : g_bad_patterns
    $error("PATTERNS must be at least 1");
  end
  if (N_OUT > SIG_W) begin : g_bad_nout
    $error("N_OUT must not exceed SIG_W");
  end
  if ((CNT_W < 32) && ((64'd1 << CNT_W) <= 64'(PATTERNS))) begin : g_bad_cntw
    $error("CNT_W too narrow for PATTERNS");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [N_IN-1:0]  x_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_abs;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             iss_q;   // a pattern was loaded into cut_x at the last edge
  logic             absorb;  // cut_f belongs to an issued pattern this cycle
  logic             pend;    // some issued pattern is still awaiting absorption

  function automatic logic [N_IN-1:0] lfsr_next(input logic [N_IN-1:0] v);
    return {v[N_IN-2:0], ^(v & LFSR_TAPS)};
  endfunction

  always_comb begin
    sig_abs = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(cut_f);
  end

  // Valid tracks each issued pattern through the CUT pipeline.
  if (CUT_LAT == 0) begin : g_nopipe
    assign absorb = iss_q;
    assign pend   = iss_q;
  end else begin : g_pipe
    logic [CUT_LAT-1:0] vpipe_q;
    logic [CUT_LAT:0]   vpipe_sh;
    assign vpipe_sh = {vpipe_q, iss_q};
    always_ff @(posedge clk) begin
      if (rst) vpipe_q <= '0;
      else     vpipe_q <= vpipe_sh[CUT_LAT-1:0];
    end
    assign absorb = vpipe_q[CUT_LAT-1];
    assign pend   = iss_q | (|vpipe_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      sig_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      iss_q   <= 1'b0;
    end else begin
      iss_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (ctl.start) begin
            // An all-zero seed would lock the LFSR up.
            x_q     <= (ctl.seed == '0) ? '1 : ctl.seed;
            sig_q   <= '0;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            iss_q   <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (absorb) sig_q <= sig_abs;
          if (cnt_q == CNT_W'(PATTERNS)) begin
            state_q <= StDrain;
          end else begin
            x_q   <= lfsr_next(x_q);
            cnt_q <= cnt_q + CNT_W'(1);
            iss_q <= 1'b1;
          end
        end
        StDrain: begin
          if (absorb) sig_q <= sig_abs;
          if (!pend) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_q == ctl.golden);
          end
        end
      endcase
    end
  end

  assign cut_x         = x_q;
  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;
  assign ctl.signature = sig_q;
  assign ctl.pat_cnt   = cnt_q;

endmodule

// File: tb/tb_cg_bist_sequencer.sv
// Bench for cg_bist_sequencer: four instances (P/L = 1/0, 2/0, 4/0, 4/2) with stub CUTs f = x[10:0],
// checked against a reference model of the LFSR/MISR rules.
module tb_cg_bist_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_s  [4];
  logic [24:0] seed_s   [4];
  logic [15:0] golden_s [4];
  logic [24:0] cut_x_s  [4];
  logic        busy_s   [4];
  logic        done_s   [4];
  logic        pass_s   [4];
  logic [15:0] sig_s    [4];
  logic [15:0] cnt_s    [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned P = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int unsigned L = (g == 3) ? 2 : 0;

    cg_bist_sequencer_if #(.N_IN(25), .SIG_W(16), .CNT_W(16)) bif ();
    logic [10:0] f;

    assign bif.start  = start_s[g];
    assign bif.seed   = seed_s[g];
    assign bif.golden = golden_s[g];
    assign busy_s[g]  = bif.busy;
    assign done_s[g]  = bif.done;
    assign pass_s[g]  = bif.pass;
    assign sig_s[g]   = bif.signature;
    assign cnt_s[g]   = bif.pat_cnt;

    if (L == 0) begin : g_comb
      assign f = cut_x_s[g][10:0];
    end else begin : g_delay
      logic [10:0] d1, d2;
      always_ff @(posedge clk) begin
        d1 <= cut_x_s[g][10:0];
        d2 <= d1;
      end
      assign f = d2;
    end

    cg_bist_sequencer #(
      .N_IN(25), .N_OUT(11), .SIG_W(16), .PATTERNS(P), .CUT_LAT(L),
      .LFSR_TAPS(25'h1200000), .MISR_POLY(16'h1021), .CNT_W(16)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .ctl   (bif),
      .cut_x (cut_x_s[g]),
      .cut_f (f)
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int p_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : 4;
  endfunction

  function automatic int l_of(input int g);
    return (g == 3) ? 2 : 0;
  endfunction

  // Reference: polynomial x^25+x^22+1 feedback, MISR over p responses f = x[10:0].
  function automatic void model(input logic [24:0] sd, input int p,
                                output logic [15:0] sig, output logic [24:0] xf);
    logic [24:0] x;
    int unsigned s;
    x = (sd == 25'd0) ? 25'h1FFFFFF : sd;
    s = 0;
    for (int i = 0; i < p; i++) begin
      s = ((s * 2) % 65536) ^ ((s >= 32768) ? 32'h1021 : 32'h0) ^ int'(x[10:0]);
      if (i != p - 1) x = {x[23:0], x[24] ^ x[21]};
    end
    sig = s[15:0];
    xf  = x;
  endfunction

  task automatic run(input int g, input logic [24:0] sd, input logic [15:0] gold, output int lat);
    seed_s[g]   = sd;
    golden_s[g] = gold;
    start_s[g]  = 1'b1;
    tick();
    start_s[g]  = 1'b0;
    lat = 0;
    while (done_s[g] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int g, input logic [24:0] sd,
                              input logic [15:0] gold, input int lat);
    logic [15:0] es;
    logic [24:0] ex;
    model(sd, p_of(g), es, ex);
    check({tag, "_lat"},  lat, p_of(g) + l_of(g) + 1);
    check({tag, "_sig"},  sig_s[g], es);
    check({tag, "_pass"}, pass_s[g], (es == gold) ? 1 : 0);
    check({tag, "_cnt"},  cnt_s[g], p_of(g));
    check({tag, "_x"},    cut_x_s[g], ex);
    check({tag, "_busy"}, busy_s[g], 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, lat3;
    logic [24:0] sd, ex;
    logic [15:0] gold, es;

    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0; seed_s[i] = '0; golden_s[i] = '0;
    end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_x", cut_x_s[2], 0);
    check("rst_sig", sig_s[2], 0);
    check("rst_cnt", cnt_s[2], 0);
    check("rst_flags", {busy_s[2], done_s[2], pass_s[2]}, 0);

    // Single pattern, seed 1
    seed_s[0] = 25'd1; golden_s[0] = 16'h0001; start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    check("t1_x0", cut_x_s[0], 1);
    check("t1_busy", busy_s[0], 1);
    lat = 0;
    while (done_s[0] !== 1'b1 && lat < 200) begin tick(); lat++; end
    check("t1_lat", lat + 0, 2);
    check("t1_sig", sig_s[0], 16'h0001);
    check("t1_pass", pass_s[0], 1);
    check("t1_cnt", cnt_s[0], 1);

    // Two patterns, watch the intermediate signature
    seed_s[1] = 25'd1; golden_s[1] = 16'h0000; start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    check("t2_x0", cut_x_s[1], 1);
    check("t2_sig0", sig_s[1], 0);
    tick();
    check("t2_x1", cut_x_s[1], 2);
    check("t2_sig1", sig_s[1], 1);
    lat = 1;
    while (done_s[1] !== 1'b1 && lat < 200) begin tick(); lat++; end
    check("t2_lat", lat, 3);
    check("t2_sig", sig_s[1], 0);
    check("t2_pass", pass_s[1], 1);
    run(1, 25'd1, 16'h1234, lat);
    check("t2b_lat", lat, 3);
    check("t2b_pass", pass_s[1], 0);

    // Zero seed: lock-up guard then LFSR advance
    seed_s[2] = 25'd0; golden_s[2] = 16'h0; start_s[2] = 1'b1;
    tick();
    start_s[2] = 1'b0;
    check("t3_x0", cut_x_s[2], 25'h1FFFFFF);
    tick();
    check("t3_x1", cut_x_s[2], 25'h1FFFFFE);
    while (done_s[2] !== 1'b1 && lat < 400) begin tick(); lat++; end
    model(25'd0, 4, es, ex);
    check("t3_sig", sig_s[2], es);

    // Same seed through combinational and 2-deep pipelined CUT
    sd = 25'($urandom);
    for (int g = 2; g < 4; g++) begin
      seed_s[g] = sd; golden_s[g] = 16'h0; start_s[g] = 1'b1;
    end
    tick();
    start_s[2] = 1'b0; start_s[3] = 1'b0;
    lat2 = 0; lat3 = 0; lat = 0;
    while ((done_s[2] !== 1'b1 || done_s[3] !== 1'b1) && lat < 200) begin
      check("t4_busy_until_done", busy_s[3], (done_s[3] === 1'b1) ? 0 : 1);
      tick();
      lat++;
      if (done_s[2] === 1'b1 && lat2 == 0) lat2 = lat;
      if (done_s[3] === 1'b1 && lat3 == 0) lat3 = lat;
    end
    check("t4_lat0", lat2, 5);
    check("t4_lat2", lat3, 7);
    model(sd, 4, es, ex);
    check("t4_sig_l0", sig_s[2], es);
    check("t4_sig_l2", sig_s[3], es);

    // Start pulses mid-run are ignored; reset mid-run clears everything
    sd = 25'($urandom) | 25'd1;
    seed_s[2] = sd; start_s[2] = 1'b1;
    tick();
    seed_s[2] = ~sd;
    tick(); tick();
    start_s[2] = 1'b0;
    model(sd, 3, es, ex);
    check("t5_cnt", cnt_s[2], 3);
    check("t5_x", cut_x_s[2], ex);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_x", cut_x_s[2], 0);
    check("t5_rst_sig", sig_s[2], 0);
    check("t5_rst_cnt", cnt_s[2], 0);
    check("t5_rst_flags", {busy_s[2], done_s[2], pass_s[2]}, 0);
    tick();
    check("t5_idle_cnt", cnt_s[2], 0);

    // Run to DONE, then re-seed straight from DONE
    run(2, 25'h0ABCDE, 16'h0, lat);
    check_result("t6a", 2, 25'h0ABCDE, 16'h0, lat);
    sd = 25'($urandom);
    model(sd, 4, es, ex);
    seed_s[2] = sd; golden_s[2] = es; start_s[2] = 1'b1;
    tick();
    start_s[2] = 1'b0;
    check("t6_done_drop", done_s[2], 0);
    check("t6_sig0", sig_s[2], 0);
    check("t6_cnt0", cnt_s[2], 1);
    check("t6_x0", cut_x_s[2], (sd == 25'd0) ? 25'h1FFFFFF : sd);
    lat = 0;
    while (done_s[2] !== 1'b1 && lat < 200) begin tick(); lat++; end
    check("t6_lat", lat, 5);
    check("t6_sig", sig_s[2], es);
    check("t6_pass", pass_s[2], 1);

    // Randomized reruns on both 4-pattern instances
    for (int k = 0; k < 8; k++) begin
      int g;
      g  = 2 + (k % 2);
      sd = (k == 3) ? 25'd0 : 25'($urandom);
      model(sd, p_of(g), es, ex);
      gold = ($urandom_range(0, 1) == 1) ? es : 16'($urandom);
      run(g, sd, gold, lat);
      check_result($sformatf("rnd%0d", k), g, sd, gold, lat);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
